// File: rtl/regfile_dual_pkg.sv
// regfile_dual_pkg: shared CPU types for the dual-issue register file.
package regfile_dual_pkg;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  creg_addr_t;
    typedef struct packed {
        logic       valid;
        creg_addr_t dst;
        word_t      value;
    } write_reg_t;
    typedef struct packed {
        logic  hi_valid;
        logic  lo_valid;
        word_t hi;
        word_t lo;
    } write_hilo_t;
    function automatic logic reg_commits(write_reg_t w);
        return w.valid && (w.dst != '0);
    endfunction
endpackage

// File: rtl/regfile_bypass.sv
// regfile_bypass: forwarding mux, slot 2 beats slot 1 beats stored state.
module regfile_bypass
    import regfile_dual_pkg::*;
#(
    parameter int BYPASS = 1
) (
    input  logic  hit1_i,
    input  word_t data1_i,
    input  logic  hit2_i,
    input  word_t data2_i,
    input  word_t stored_i,
    output word_t data_o
);
    assign data_o = (BYPASS != 0 && hit2_i) ? data2_i :
                    (BYPASS != 0 && hit1_i) ? data1_i : stored_i;
endmodule

// File: rtl/regfile_dual.sv
// regfile_dual: 2-write / NUM_RD-read GPR file with HI/LO and a write counter.
module regfile_dual
    import regfile_dual_pkg::*;
#(
    parameter int NUM_RD = 4,
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  write_reg_t  write_reg_1,
    input  write_reg_t  write_reg_2,
    input  write_hilo_t write_hilo_1,
    input  write_hilo_t write_hilo_2,
    input  creg_addr_t  raddr [NUM_RD],
    output word_t       rdata [NUM_RD],
    output word_t       hi_out,
    output word_t       lo_out,
    output logic [31:0] perf_wr_cnt
);
    word_t       gpr_q [1:31];
    word_t       gpr_d [1:31];
    word_t       hi_q, hi_d, lo_q, lo_d;
    logic [31:0] perf_q, perf_d;
    logic        c1, c2;

    assign c1 = reg_commits(write_reg_1);
    assign c2 = reg_commits(write_reg_2);

    always_comb begin
        gpr_d = gpr_q;
        for (int r = 1; r < 32; r++) begin
            if (c1 && write_reg_1.dst == 5'(r)) gpr_d[r] = write_reg_1.value;
            if (c2 && write_reg_2.dst == 5'(r)) gpr_d[r] = write_reg_2.value;
        end
        hi_d = write_hilo_2.hi_valid ? write_hilo_2.hi : write_hilo_1.hi_valid ? write_hilo_1.hi : hi_q;
        lo_d = write_hilo_2.lo_valid ? write_hilo_2.lo : write_hilo_1.lo_valid ? write_hilo_1.lo : lo_q;
        perf_d = perf_q + 32'(c1) + 32'(c2);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 1; r < 32; r++) gpr_q[r] <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            perf_q <= '0;
        end else begin
            gpr_q  <= gpr_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            perf_q <= perf_d;
        end
    end

    // c1/c2 already exclude dst 0, so a read of r0 can never be forwarded
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        word_t stored;
        assign stored = (raddr[i] == '0) ? '0 : gpr_q[raddr[i]];
        regfile_bypass #(.BYPASS(BYPASS)) u_byp (
            .hit1_i  (c1 && write_reg_1.dst == raddr[i]),
            .data1_i (write_reg_1.value),
            .hit2_i  (c2 && write_reg_2.dst == raddr[i]),
            .data2_i (write_reg_2.value),
            .stored_i(stored),
            .data_o  (rdata[i])
        );
    end

    regfile_bypass #(.BYPASS(BYPASS)) u_byp_hi (
        .hit1_i  (write_hilo_1.hi_valid),
        .data1_i (write_hilo_1.hi),
        .hit2_i  (write_hilo_2.hi_valid),
        .data2_i (write_hilo_2.hi),
        .stored_i(hi_q),
        .data_o  (hi_out)
    );

    regfile_bypass #(.BYPASS(BYPASS)) u_byp_lo (
        .hit1_i  (write_hilo_1.lo_valid),
        .data1_i (write_hilo_1.lo),
        .hit2_i  (write_hilo_2.lo_valid),
        .data2_i (write_hilo_2.lo),
        .stored_i(lo_q),
        .data_o  (lo_out)
    );

    assign perf_wr_cnt = perf_q;
endmodule

// File: tb/tb_regfile_dual.sv
// tb_regfile_dual: directed and random checks of regfile_dual against a behavioural model.
module tb_regfile_dual;
    import regfile_dual_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    write_reg_t  w1, w2;
    write_hilo_t h1, h2;
    creg_addr_t  ra [4];
    word_t       rd [4];
    word_t       hi_o, lo_o;
    logic [31:0] cnt_o;

    word_t       m_gpr [32];
    word_t       m_hi, m_lo;
    logic [31:0] m_cnt;
    int          checks = 0;
    int          failures = 0;

    regfile_dual #(.NUM_RD(4), .BYPASS(1)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .write_reg_1 (w1),
        .write_reg_2 (w2),
        .write_hilo_1(h1),
        .write_hilo_2(h2),
        .raddr       (ra),
        .rdata       (rd),
        .hi_out      (hi_o),
        .lo_out      (lo_o),
        .perf_wr_cnt (cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic word_t exp_rd(input creg_addr_t a);
        if (a == 0) return '0;
        if (w2.valid && w2.dst == a) return w2.value;
        if (w1.valid && w1.dst == a) return w1.value;
        return m_gpr[a];
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) check($sformatf("%s rd%0d a=%0d", tag, i, ra[i]), rd[i], exp_rd(ra[i]));
        check({tag, " hi"}, hi_o, h2.hi_valid ? h2.hi : h1.hi_valid ? h1.hi : m_hi);
        check({tag, " lo"}, lo_o, h2.lo_valid ? h2.lo : h1.lo_valid ? h1.lo : m_lo);
        check({tag, " cnt"}, cnt_o, m_cnt);
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) m_gpr[r] = '0;
        m_hi = '0;
        m_lo = '0;
        m_cnt = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (resetn) begin
            if (w1.valid && w1.dst != 0) begin m_gpr[w1.dst] = w1.value; m_cnt++; end
            if (w2.valid && w2.dst != 0) begin m_gpr[w2.dst] = w2.value; m_cnt++; end
            if (h1.hi_valid) m_hi = h1.hi;
            if (h2.hi_valid) m_hi = h2.hi;
            if (h1.lo_valid) m_lo = h1.lo;
            if (h2.lo_valid) m_lo = h2.lo;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        w1 = '0; w2 = '0; h1 = '0; h2 = '0;
    endtask

    initial begin
        idle();
        for (int i = 0; i < 4; i++) ra[i] = '0;
        model_clear();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        // every address reads zero out of reset
        for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < 4; i++) ra[i] = 5'(g * 4 + i);
            #1 check_all("reset");
        end
        @(negedge clk);
        // same-cycle collision on r5: slot 2 wins, counts 2
        w1 = {1'b1, 5'd5, 32'h1234_5678};
        w2 = {1'b1, 5'd5, 32'hDEAD_BEEF};
        ra[0] = 5'd5;
        #1 check_all("coll_same");
        check("coll_same r5", rd[0], 32'hDEAD_BEEF);
        tick(); idle();
        #1 check_all("coll_next");
        check("coll_next r5", rd[0], 32'hDEAD_BEEF);
        check("coll_next cnt", cnt_o, 32'd2);
        // write to r0 is discarded and not counted
        w1 = {1'b1, 5'd0, 32'hFFFF_FFFF};
        ra[1] = 5'd0;
        #1 check_all("r0_same");
        check("r0_same rd1", rd[1], 32'h0);
        tick(); idle();
        #1 check_all("r0_next");
        check("r0_next cnt", cnt_o, 32'd2);
        // independent HI/LO updates, then slot 2 winning HI
        h1 = {1'b1, 1'b0, 32'h1, 32'h0};
        h2 = {1'b0, 1'b1, 32'h0, 32'h2};
        #1 check_all("hilo_a");
        tick(); idle();
        #1 check("hilo_a hi", hi_o, 32'h1);
        check("hilo_a lo", lo_o, 32'h2);
        h1 = {1'b1, 1'b0, 32'h3, 32'h0};
        h2 = {1'b1, 1'b0, 32'h4, 32'h0};
        #1 check_all("hilo_b");
        tick(); idle();
        #1 check("hilo_b hi", hi_o, 32'h4);
        check("hilo_b lo", lo_o, 32'h2);
        // asynchronous reset between edges, write on the reset edge dropped
        w1 = {1'b1, 5'd7, 32'hA5A5_A5A5};
        ra[2] = 5'd7;
        tick(); idle();
        #1 check("r7 stored", rd[2], 32'hA5A5_A5A5);
        #1 resetn = 1'b0;
        model_clear();
        w2 = {1'b1, 5'd9, 32'h1111_1111};
        ra[3] = 5'd9;
        #1 check_all("in_reset");
        check("in_reset r7", rd[2], 32'h0);
        tick();
        resetn = 1'b1;
        idle();
        #1 check_all("post_reset");
        check("post_reset r9", rd[3], 32'h0);
        // random traffic with a narrow address range to provoke collisions
        for (int n = 0; n < 300; n++) begin
            w1 = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom)};
            w2 = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom)};
            h1 = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom)};
            h2 = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom)};
            for (int i = 0; i < 4; i++) ra[i] = 5'($urandom_range(0, 9));
            #1 check_all("rnd");
            tick();
        end
        idle();
        // counter wrap from all-ones
        #1 force dut.perf_q = 32'hFFFF_FFFF;
        #1 release dut.perf_q;
        m_cnt = 32'hFFFF_FFFF;
        #1 check("wrap pre", cnt_o, 32'hFFFF_FFFF);
        w1 = {1'b1, 5'd3, 32'h0000_0033};
        w2 = {1'b1, 5'd4, 32'h0000_0044};
        tick(); idle();
        #1 check_all("wrap");
        check("wrap cnt", cnt_o, 32'h0000_0001);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
